// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch program counter sequencer.
// Walks BOOT -> FETCH <-> STALL, and HALTED on a halt instruction.
// Taken redirects follow the priority halt > jump > branch > pc+4.
// The instruction counter counts every accepted instruction.
// Optional macro PC_SEQ_MISALIGN_TRAP_EN: a misaligned redirect target
// loads TRAP_VECTOR and sets the sticky misalign flag. When the macro is
// undefined, the target is word-aligned by clearing bits [1:0] and
// misalign is always 0.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] retire_cnt,
  output logic        misalign,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    STALL  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] retire_cnt_r;
  logic        imem_req_r;
  logic [31:0] target_s;
  logic [31:0] next_pc_s;
  logic        accept_s;

  assign accept_s    = (state_r == FETCH) && imem_ready && !stall;
  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign retire_cnt  = retire_cnt_r;
  assign state       = state_r;
  assign instr_valid = imem_req_r & imem_ready;

  // Next PC on an accepted instruction: halt holds, then jump, branch, sequential.
  always_comb begin
    target_s  = jump ? jump_target : branch_target;
    next_pc_s = pc_r;
    if (halt) begin
      next_pc_s = pc_r;
    end else if (jump || branch_taken) begin
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      if (target_s[1:0] != 2'b00) begin
        next_pc_s = TRAP_VECTOR;
      end else begin
        next_pc_s = target_s;
      end
`else
      next_pc_s = target_s & ~32'd3;
`endif
    end else begin
      next_pc_s = pc_r + 32'd4;
    end
  end

  // Sequencer FSM with PC, retire counter and fetch request held in registers.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_r      <= BOOT;
      pc_r         <= RESET_VECTOR;
      retire_cnt_r <= 32'd0;
      imem_req_r   <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          state_r    <= FETCH;
          imem_req_r <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            if (stall) begin
              // Redirects and halt are ignored while downstream is busy.
              state_r    <= STALL;
              imem_req_r <= 1'b0;
            end else begin
              retire_cnt_r <= retire_cnt_r + 32'd1;
              pc_r         <= next_pc_s;
              if (halt) begin
                state_r    <= HALTED;
                imem_req_r <= 1'b0;
              end else begin
                state_r    <= FETCH;
                imem_req_r <= 1'b1;
              end
            end
          end else begin
            state_r    <= FETCH;
            imem_req_r <= 1'b1;
          end
        end
        STALL: begin
          if (!stall) begin
            // Same address is refetched once downstream frees up.
            state_r    <= FETCH;
            imem_req_r <= 1'b1;
          end else begin
            state_r    <= STALL;
            imem_req_r <= 1'b0;
          end
        end
        HALTED: begin
          state_r    <= HALTED;
          imem_req_r <= 1'b0;
        end
        default: begin
          state_r    <= BOOT;
          imem_req_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic misalign_r;
  logic trap_s;

  // A redirect (not overridden by halt) to a non-word address traps.
  always_comb begin
    trap_s = 1'b0;
    if (!halt && (jump || branch_taken) && (target_s[1:0] != 2'b00)) begin
      trap_s = 1'b1;
    end else begin
      trap_s = 1'b0;
    end
  end

  // Sticky misalign flag, cleared only by reset.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      misalign_r <= 1'b0;
    end else if (accept_s && trap_s) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign misalign = misalign_r;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        a_rst = 1'b0;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] retire_cnt;
  logic        misalign;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  localparam logic MIS = 1'b1;
`else
  localparam logic MIS = 1'b0;
`endif

  pc_sequencer dut (
    .clk(clk), .a_rst(a_rst), .imem_ready(imem_ready), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .instr_valid(instr_valid),
    .pc(pc), .retire_cnt(retire_cnt), .misalign(misalign), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        stl;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        hlt;
    logic [31:0] e_pc;
    logic [1:0]  e_st;
    logic        e_req;
    logic [31:0] e_cnt;
    logic        e_mis;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic rdy, logic stl, logic br, logic [31:0] bt,
                              logic jmp, logic [31:0] jt, logic hlt,
                              logic [31:0] e_pc, logic [1:0] e_st, logic e_req,
                              logic [31:0] e_cnt, logic e_mis);
    vec_t v;
    v.rdy = rdy; v.stl = stl; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
    v.hlt = hlt; v.e_pc = e_pc; v.e_st = e_st; v.e_req = e_req;
    v.e_cnt = e_cnt; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [1:0] e_st,
                         input logic e_req, input logic [31:0] e_cnt, input logic e_mis);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".imem_addr"}, imem_addr, e_pc);
    chk({tag, ".state"}, {30'd0, state}, {30'd0, e_st});
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
    chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_req & imem_ready});
    chk({tag, ".retire_cnt"}, retire_cnt, e_cnt);
    chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
  endtask

  task automatic drive(input logic rdy, input logic stl, input logic br, input logic [31:0] bt,
                       input logic jmp, input logic [31:0] jt, input logic hlt);
    imem_ready = rdy; stall = stl; branch_taken = br; branch_target = bt;
    jump = jmp; jump_target = jt; halt = hlt;
  endtask

  initial begin
    //             rdy  stl  br   bt             jmp  jt             hlt  pc             st     req  cnt     mis
    vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_0000,2'd1,1'b1,32'd0, 1'b0);
    vecs[1]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_0004,2'd1,1'b1,32'd1, 1'b0);
    vecs[2]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_0008,2'd1,1'b1,32'd2, 1'b0);
    vecs[3]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_000C,2'd1,1'b1,32'd3, 1'b0);
    vecs[4]  = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_0010,2'd1,1'b1,32'd4, 1'b0);
    vecs[5]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_0010,2'd1,1'b1,32'd4, 1'b0);
    vecs[6]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h200,      1'b1,32'h0000_0010,2'd1,1'b1,32'd4, 1'b0);
    vecs[7]  = mk(1'b1,1'b1,1'b0,32'h0,        1'b1,32'h200,      1'b1,32'h0000_0010,2'd2,1'b0,32'd4, 1'b0);
    vecs[8]  = mk(1'b1,1'b1,1'b1,32'h300,      1'b0,32'h0,        1'b0,32'h0000_0010,2'd2,1'b0,32'd4, 1'b0);
    vecs[9]  = mk(1'b1,1'b0,1'b1,32'h300,      1'b0,32'h0,        1'b0,32'h0000_0010,2'd1,1'b1,32'd4, 1'b0);
    vecs[10] = mk(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h20,       1'b0,32'h0000_0020,2'd1,1'b1,32'd5, 1'b0);
    vecs[11] = mk(1'b1,1'b0,1'b1,32'h80,       1'b1,32'h400,      1'b0,32'h0000_0400,2'd1,1'b1,32'd6, 1'b0);
    vecs[12] = mk(1'b1,1'b0,1'b1,32'h8,        1'b0,32'h0,        1'b0,32'h0000_0008,2'd1,1'b1,32'd7, 1'b0);
    vecs[13] = mk(1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_0008,2'd2,1'b0,32'd7, 1'b0);
    vecs[14] = mk(1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_0008,2'd2,1'b0,32'd7, 1'b0);
    vecs[15] = mk(1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_0008,2'd2,1'b0,32'd7, 1'b0);
    vecs[16] = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_0008,2'd1,1'b1,32'd7, 1'b0);
    vecs[17] = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_000C,2'd1,1'b1,32'd8, 1'b0);
    vecs[18] = mk(1'b1,1'b0,1'b1,32'h102,      1'b0,32'h0,        1'b0,32'h0000_0100,2'd1,1'b1,32'd9, MIS);
    vecs[19] = mk(1'b1,1'b0,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,1'b0,32'hFFFF_FFFC,2'd1,1'b1,32'd10,MIS);
    vecs[20] = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0000_0000,2'd1,1'b1,32'd11,MIS);
    vecs[21] = mk(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h30,       1'b0,32'h0000_0030,2'd1,1'b1,32'd12,MIS);
    vecs[22] = mk(1'b1,1'b0,1'b1,32'h44,       1'b1,32'h500,      1'b1,32'h0000_0030,2'd3,1'b0,32'd13,MIS);
    vecs[23] = mk(1'b1,1'b0,1'b0,32'h0,        1'b1,32'h600,      1'b0,32'h0000_0030,2'd3,1'b0,32'd13,MIS);

    // Reset asserted with no clock edge yet: values appear immediately.
    #1 a_rst = 1'b1;
    #1 chk_all("reset", 32'h0, 2'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    a_rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rdy, vecs[i].stl, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt, vecs[i].hlt);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_st, vecs[i].e_req,
              vecs[i].e_cnt, vecs[i].e_mis);
    end

    // Asynchronous reset pulse between edges while HALTED.
    #2 a_rst = 1'b1;
    #1 chk_all("rst_halted", 32'h0, 2'd0, 1'b0, 32'd0, 1'b0);
    #1 a_rst = 1'b0;

    // BOOT -> FETCH, then stall into STALL and reset from there.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk_all("boot2", 32'h0, 2'd1, 1'b1, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0);
    @(posedge clk); #1;
    chk_all("stall2", 32'h0, 2'd2, 1'b0, 32'd0, 1'b0);
    #2 a_rst = 1'b1;
    #1 chk_all("rst_stall", 32'h0, 2'd0, 1'b0, 32'd0, 1'b0);
    #1 a_rst = 1'b0;

    // Retire counter wrap from all-ones.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk_all("boot3", 32'h0, 2'd1, 1'b1, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    force dut.retire_cnt_r = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_r;
    @(posedge clk); #1;
    chk_all("cnt_preload", 32'h0, 2'd1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk_all("cnt_wrap", 32'h4, 2'd1, 1'b1, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
